// File: rtl/rand_slice_buffer.sv
// Buffers whole words from a single-cycle random generator and serves them as
// narrow LSB-first slices to one consumer over a valid/ready handshake.
module rand_slice_buffer #(
    parameter int SRC_W = 256,
    parameter int OUT_W = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic                         gen_en,
    input  logic [SRC_W-1:0]             gen_rand,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             words_used
);

    localparam int NSL   = SRC_W / OUT_W;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [SRC_W-1:0] mem_q [DEPTH];

    logic [LVL_W-1:0] level_q, level_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] words_used_q, words_used_d;

    logic xfer;
    logic last_slice;
    logic pop;
    logic push;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    function automatic logic [OUT_W-1:0] slice_of(input logic [SRC_W-1:0] word,
                                                  input logic [IDX_W-1:0] idx);
        logic [OUT_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < NSL; i++) begin
            if (idx == IDX_W'(i)) begin
                sel = word[i*OUT_W +: OUT_W];
            end
        end
        return sel;
    endfunction

    always_comb begin
        // Refill never looks at out_ready: a full buffer waits one cycle after a pop.
        gen_en     = en & ~rst & (level_q < LVL_W'(DEPTH));
        out_valid  = (level_q != '0);
        xfer       = out_valid & out_ready;
        last_slice = (idx_q == IDX_W'(NSL - 1));
        pop        = xfer & last_slice;
        push       = gen_en;

        idx_d = idx_q;
        if (xfer) begin
            idx_d = last_slice ? '0 : idx_q + 1'b1;
        end

        head_d = pop  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        words_used_d = pop ? words_used_q + CNT_W'(1) : words_used_q;

        out_data = out_valid ? slice_of(mem_q[head_q], idx_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            idx_q        <= '0;
            words_used_q <= '0;
        end else begin
            level_q      <= level_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            idx_q        <= idx_d;
            words_used_q <= words_used_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= gen_rand;
        end
    end

    assign level      = level_q;
    assign words_used = words_used_q;

endmodule

// File: tb/tb_rand_slice_buffer.sv
// Directed and randomized bench for rand_slice_buffer; a slice-queue model
// predicts every output each cycle.
module tb_rand_slice_buffer;

    localparam int SRC_W = 256;
    localparam int OUT_W = 16;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int NSL   = SRC_W / OUT_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 gen_en;
    logic [SRC_W-1:0]     gen_rand;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [1:0]           level;
    logic [CNT_W-1:0]     words_used;

    rand_slice_buffer #(
        .SRC_W(SRC_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .gen_en(gen_en), .gen_rand(gen_rand),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .words_used(words_used)
    );

    always #5 clk = ~clk;

    // Generator model: word k holds slice value k*16+j in slice j.
    int gk;
    always_comb begin
        for (int j = 0; j < NSL; j++) begin
            gen_rand[j*OUT_W +: OUT_W] = 16'(gk * NSL + j);
        end
    end

    logic [15:0] mq[$];
    int m_used;
    int checks;
    int passes;
    int dut_xfer;
    int dut_gen;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: check outputs against the model, advance the model, take the edge.
    task automatic cyc();
        int   lvl;
        logic eg;
        logic adv;
        #1;
        lvl = (mq.size() + NSL - 1) / NSL;
        eg  = en && !rst && (lvl < DEPTH);
        chk("gen_en", 32'(gen_en), 32'(eg));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : 16'h0));
        chk("level", 32'(level), 32'(lvl));
        chk("words_used", 32'(words_used), 32'(m_used % 16));
        if (out_valid && out_ready) dut_xfer++;
        if (gen_en) dut_gen++;
        if (rst) begin
            mq.delete();
            m_used = 0;
        end else begin
            if (mq.size() != 0 && out_ready) begin
                void'(mq.pop_front());
                if (mq.size() % NSL == 0) m_used++;
            end
            if (eg) begin
                for (int j = 0; j < NSL; j++) mq.push_back(16'(gk * NSL + j));
            end
        end
        adv = gen_en;
        @(posedge clk);
        @(negedge clk);
        if (adv) gk++;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; passes = 0; gk = 0; m_used = 0; dut_xfer = 0; dut_gen = 0;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;

        // Fill and drain
        en = 1'b1; out_ready = 1'b0; dut_gen = 0;
        repeat (5) cyc();
        chk("fill_gen_cycles", 32'(dut_gen), 32'd2);
        chk("fill_level", 32'(level), 32'd2);
        chk("fill_valid", 32'(out_valid), 32'd1);
        chk("fill_data", 32'(out_data), 32'h0000);

        // Full-rate stream
        out_ready = 1'b1; dut_xfer = 0;
        repeat (48) cyc();
        chk("stream_xfers", 32'(dut_xfer), 32'd48);
        chk("stream_used", 32'(words_used), 32'd3);

        // Backpressure
        reset_cycle();
        base = gk;
        en = 1'b1; out_ready = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1; cyc();
        out_ready = 1'b0; cyc();
        chk("bp_hold1", 32'(out_data), 32'(16'(base * NSL + 1)));
        cyc();
        chk("bp_hold2", 32'(out_data), 32'(16'(base * NSL + 1)));
        out_ready = 1'b1; cyc();
        chk("bp_next", 32'(out_data), 32'(16'(base * NSL + 2)));

        // en drop at level=2, idx=5
        reset_cycle();
        en = 1'b1; out_ready = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("drop_level_start", 32'(level), 32'd2);
        en = 1'b0; dut_xfer = 0;
        for (int n = 0; n < 60 && out_valid; n++) cyc();
        chk("drop_xfers", 32'(dut_xfer), 32'd27);
        #1;
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("drop_gen_en", 32'(gen_en), 32'd0);
        chk("drop_level", 32'(level), 32'd0);
        cyc();

        // Reset mid-word at idx=7
        en = 1'b1; out_ready = 1'b0;
        repeat (3) cyc();
        out_ready = 1'b1;
        repeat (7) cyc();
        reset_cycle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_used", 32'(words_used), 32'd0);
        base = gk;
        cyc();
        chk("rst_first_slice", 32'(out_data), 32'(16'(base * NSL)));
        repeat (4) cyc();

        // Counter wrap: 17 words on a 4-bit counter
        reset_cycle();
        en = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 400 && m_used < 17; n++) cyc();
        #1;
        chk("wrap_used", 32'(words_used), 32'd1);
        cyc();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
